// File: rtl/pipe_mult_hs.sv
// pipe_mult_hs: pipelined WIDTH x WIDTH -> 2*WIDTH multiplier with valid/ready
// on both sides. Operands are reduced to magnitudes at entry. Each stage
// accumulates |A| times one WIDTH/STAGES-bit slice of |B|. The last stage
// applies the recorded sign. Empty stages accept new work while later
// stages are stalled, so bubbles collapse under backpressure.
module pipe_mult_hs #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int TAG_W  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_signed,
   input  logic [WIDTH-1:0]             A,
   input  logic [WIDTH-1:0]             B,
   input  logic [TAG_W-1:0]             in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [2*WIDTH-1:0]           F,
   output logic [TAG_W-1:0]             out_tag,
   output logic [$clog2(STAGES+1)-1:0]  occupancy
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int PW    = 2 * WIDTH;
   localparam int OCC_W = $clog2(STAGES + 1);

   // Magnitude of an operand: negate only when it is signed and negative.
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic sgn);
      if (sgn && x[WIDTH-1]) begin
         mag_f = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag_f = x;
      end
   endfunction

   // Two's complement negation over the full product width.
   function automatic logic [PW-1:0] neg_f(input logic [PW-1:0] x);
      neg_f = ~x + {{(PW-1){1'b0}}, 1'b1};
   endfunction

   // Number of set bits in a stage-valid vector.
   function automatic logic [OCC_W-1:0] popcount_f(input logic [STAGES-1:0] v);
      logic [OCC_W-1:0] cnt;
      cnt = {OCC_W{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
         cnt = cnt + OCC_W'(v[i]);
      end
      popcount_f = cnt;
   endfunction

   logic [STAGES-1:0] v_all_s;
   logic [STAGES-1:0] nv_all_s;
   logic [STAGES-1:0] en_s;
   logic [WIDTH-1:0]  a_mag_s;
   logic [WIDTH-1:0]  b_mag_s;
   logic              in_neg_s;
   logic [OCC_W-1:0]  occupancy_r;

   // A stage may load when the output is draining or any stage at or after it is empty.
   always_comb begin
      logic any_empty;
      any_empty = 1'b0;
      en_s      = {STAGES{1'b0}};
      for (int k = STAGES - 1; k >= 0; k--) begin
         any_empty = any_empty | ~v_all_s[k];
         en_s[k]   = out_ready | any_empty;
      end
   end

   assign in_ready = en_s[0];

   // Entry conditioning: magnitudes and the result sign (only meaningful when signed).
   always_comb begin
      a_mag_s  = mag_f(A, in_signed);
      b_mag_s  = mag_f(B, in_signed);
      in_neg_s = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int SW = WIDTH - k * CHUNK;

      logic             v_r;
      logic [TAG_W-1:0] tag_r;
      logic [PW-1:0]    sum_r;

      logic             src_v_s;
      logic [TAG_W-1:0] src_tag_s;
      logic             src_neg_s;
      logic [WIDTH-1:0] src_a_s;
      logic [SW-1:0]    src_b_s;
      logic [PW-1:0]    src_sum_s;
      logic [PW-1:0]    acc_s;
      logic [PW-1:0]    nxt_sum_s;

      if (k == 0) begin : g_src
         assign src_v_s   = in_valid;
         assign src_tag_s = in_tag;
         assign src_neg_s = in_neg_s;
         assign src_a_s   = a_mag_s;
         assign src_b_s   = b_mag_s;
         assign src_sum_s = {PW{1'b0}};
      end else begin : g_src
         assign src_v_s   = g_stage[k-1].v_r;
         assign src_tag_s = g_stage[k-1].tag_r;
         assign src_neg_s = g_stage[k-1].g_carry.neg_r;
         assign src_a_s   = g_stage[k-1].g_carry.a_r;
         assign src_b_s   = g_stage[k-1].g_carry.b_r;
         assign src_sum_s = g_stage[k-1].sum_r;
      end

      // Add this stage's slice product, shifted to its bit position.
      always_comb begin
         acc_s = src_sum_s
               + (({{WIDTH{1'b0}}, src_a_s} * {{(PW-CHUNK){1'b0}}, src_b_s[CHUNK-1:0]})
                  << (k * CHUNK));
      end

      if (k == STAGES - 1) begin : g_fin
         assign nxt_sum_s = src_neg_s ? neg_f(acc_s) : acc_s;
      end else begin : g_fin
         assign nxt_sum_s = acc_s;
      end

      assign v_all_s[k]  = v_r;
      assign nv_all_s[k] = en_s[k] ? src_v_s : v_r;

      // Stage valid, tag and partial sum; data only moves with a valid source.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_r   <= 1'b0;
            tag_r <= {TAG_W{1'b0}};
            sum_r <= {PW{1'b0}};
         end else if (en_s[k]) begin
            v_r <= src_v_s;
            if (src_v_s) begin
               tag_r <= src_tag_s;
               sum_r <= nxt_sum_s;
            end
         end
      end

      if (k < STAGES - 1) begin : g_carry
         localparam int RW = SW - CHUNK;
         logic             neg_r;
         logic [WIDTH-1:0] a_r;
         logic [RW-1:0]    b_r;

         // Operands still needed downstream: sign, |A| and the unconsumed |B| bits.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               neg_r <= 1'b0;
               a_r   <= {WIDTH{1'b0}};
               b_r   <= {RW{1'b0}};
            end else if (en_s[k] && src_v_s) begin
               neg_r <= src_neg_s;
               a_r   <= src_a_s;
               b_r   <= src_b_s[SW-1:CHUNK];
            end
         end
      end
   end

   // Registered count of stages that hold a transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy_r <= {OCC_W{1'b0}};
      end else begin
         occupancy_r <= popcount_f(nv_all_s);
      end
   end

   assign out_valid = g_stage[STAGES-1].v_r;
   assign F         = g_stage[STAGES-1].sum_r;
   assign out_tag   = g_stage[STAGES-1].tag_r;
   assign occupancy = occupancy_r;

endmodule
